// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
// Holds the sequencer state enum, the zero register address and the wait-counter width.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        MEMWAIT = 2'b01
    } state_e;

    localparam logic [4:0] ZERO_REG = 5'd0;
    localparam int unsigned WAIT_W  = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: holds at all-ones, synchronous clear beats increment.
// Ports: clk_i clock, clr_i clear, inc_i increment, cnt_o current count.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Inputs: ID/EX register addresses, load in EX, taken branch, memory req/ack, counter clear.
// Outputs: per-stage stall/flush/bubble controls, sticky timeout err_o, three perf counters.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 64,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       id_rs_addr_i,
    input  logic [4:0]       id_rt_addr_i,
    input  logic             id_uses_rt_i,
    input  logic             ex_memread_i,
    input  logic [4:0]       ex_rt_addr_i,
    input  logic             branch_taken_i,
    input  logic             mem_req_i,
    input  logic             mem_ack_i,
    input  logic             cnt_clr_i,
    output logic             pc_stall_o,
    output logic             ifid_stall_o,
    output logic             ifid_flush_o,
    output logic             idex_stall_o,
    output logic             idex_bubble_o,
    output logic             exmem_stall_o,
    output logic             memwb_bubble_o,
    output logic             err_o,
    output logic [CNT_W-1:0] loaduse_cnt_o,
    output logic [CNT_W-1:0] memstall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam logic [WAIT_W-1:0] TMO = WAIT_W'(MEM_TIMEOUT);

    state_e            state_q;
    logic              err_q;
    logic [WAIT_W-1:0] wait_cnt;
    logic              mem_stall;
    logic              load_use;
    logic              win_ms;
    logic              win_lu;
    logic              win_br;

    assign mem_stall = mem_req_i & ~mem_ack_i;

    assign load_use = ex_memread_i
                    & (ex_rt_addr_i != ZERO_REG)
                    & ((ex_rt_addr_i == id_rs_addr_i)
                     | (id_uses_rt_i & (ex_rt_addr_i == id_rt_addr_i)));

    // One-hot winner of the priority chain; nothing wins during reset.
    assign win_ms = ~rst_i & mem_stall;
    assign win_lu = ~rst_i & ~mem_stall & load_use;
    assign win_br = ~rst_i & ~mem_stall & ~load_use & branch_taken_i;

    always_comb begin
        pc_stall_o     = 1'b0;
        ifid_stall_o   = 1'b0;
        ifid_flush_o   = 1'b0;
        idex_stall_o   = 1'b0;
        idex_bubble_o  = 1'b0;
        exmem_stall_o  = 1'b0;
        memwb_bubble_o = 1'b0;
        if (rst_i) begin
            idex_bubble_o  = 1'b1;
            memwb_bubble_o = 1'b1;
        end else if (win_ms) begin
            pc_stall_o     = 1'b1;
            ifid_stall_o   = 1'b1;
            idex_stall_o   = 1'b1;
            exmem_stall_o  = 1'b1;
            memwb_bubble_o = 1'b1;
        end else if (win_lu) begin
            pc_stall_o     = 1'b1;
            ifid_stall_o   = 1'b1;
            idex_bubble_o  = 1'b1;
        end else if (win_br) begin
            ifid_flush_o   = 1'b1;
        end
    end

    // Dropping req mid-wait is a protocol error: leave MEMWAIT and flag it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= RUN;
            err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (mem_stall) state_q <= MEMWAIT;
                end
                MEMWAIT: begin
                    if (!mem_req_i || mem_ack_i) state_q <= RUN;
                    if (!mem_req_i || (wait_cnt >= TMO)) err_q <= 1'b1;
                end
                default: state_q <= RUN;
            endcase
        end
    end

    assign err_o = err_q;

    sat_counter #(.W(WAIT_W)) u_wait (
        .clk_i (clk_i),
        .clr_i (rst_i | ((state_q == RUN) & mem_stall)),
        .inc_i ((state_q == MEMWAIT) & mem_stall),
        .cnt_o (wait_cnt)
    );

    sat_counter #(.W(CNT_W)) u_lu_cnt (
        .clk_i (clk_i),
        .clr_i (rst_i | cnt_clr_i),
        .inc_i (win_lu),
        .cnt_o (loaduse_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_ms_cnt (
        .clk_i (clk_i),
        .clr_i (rst_i | cnt_clr_i),
        .inc_i (win_ms),
        .cnt_o (memstall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_fl_cnt (
        .clk_i (clk_i),
        .clr_i (rst_i | cnt_clr_i),
        .inc_i (win_br),
        .cnt_o (flush_cnt_o)
    );

endmodule
